// File: rtl/frame_block_scheduler.sv
// frame_block_scheduler: hands frame-buffer blocks to the camera writer,
// publishes the newest finished block to the display reader, and optionally
// freezes one block for a screenshot (compile with SCREENSHOT_EN defined).
// Same-cycle events resolve in the order: write done, read start, write start.
module frame_block_scheduler #(
    parameter int BLOCK_NUM = 3
) (
    input  logic       clk,
    input  logic       rest_n,
    input  logic       wr_frame_start,
    input  logic       wr_frame_done,
    output logic [1:0] wr_block,
    output logic       wr_ok,
    input  logic       rd_frame_start,
    output logic [1:0] rd_block,
    output logic       rd_valid,
    input  logic       shot_req,
    output logic [1:0] shot_block,
    output logic       shot_valid,
    output logic [7:0] drop_cnt
);

    logic [1:0] latest_blk;
    logic       latest_valid;

    logic [1:0] wr_block_n;
    logic       wr_ok_n;
    logic [1:0] rd_block_n;
    logic       rd_valid_n;
    logic [1:0] latest_blk_n;
    logic       latest_valid_n;
    logic [7:0] drop_cnt_n;
    logic [3:0] excluded;
    logic [3:0] shot_excl;
    logic [1:0] free_blk;
    logic       free_found;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef SCREENSHOT_EN
    logic       shot_req_d;
    logic [1:0] shot_block_n;
    logic       shot_valid_n;

    // Capture the newest published block on a shot_req rise, release on its fall.
    always_comb begin
        shot_block_n = shot_block;
        shot_valid_n = shot_valid;
        shot_excl    = '0;
        if (shot_req && !shot_req_d && latest_valid_n) begin
            shot_block_n = latest_blk_n;
            shot_valid_n = 1'b1;
        end else if (!shot_req && shot_req_d) begin
            shot_valid_n = 1'b0;
        end
        if (shot_valid_n) begin
            shot_excl[shot_block_n] = 1'b1;
        end
    end

    // Screenshot state registers.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            shot_req_d <= 1'b0;
            shot_block <= '0;
            shot_valid <= 1'b0;
        end else begin
            shot_req_d <= shot_req;
            shot_block <= shot_block_n;
            shot_valid <= shot_valid_n;
        end
    end
`else
    logic unused_shot_req;
    assign unused_shot_req = shot_req;
    assign shot_excl       = '0;
    assign shot_block      = '0;
    assign shot_valid      = 1'b0;
`endif

    // Resolve done, then read start, then write start, so each later event
    // sees the effects of the earlier ones within the same cycle.
    always_comb begin
        wr_block_n     = wr_block;
        wr_ok_n        = wr_ok;
        rd_block_n     = rd_block;
        rd_valid_n     = rd_valid;
        latest_blk_n   = latest_blk;
        latest_valid_n = latest_valid;
        drop_cnt_n     = drop_cnt;
        excluded       = '0;
        free_blk       = '0;
        free_found     = 1'b0;

        if (wr_frame_done && wr_ok) begin
            latest_blk_n   = wr_block;
            latest_valid_n = 1'b1;
            wr_ok_n        = 1'b0;
        end

        if (rd_frame_start && latest_valid_n) begin
            rd_block_n = latest_blk_n;
            rd_valid_n = 1'b1;
        end

        for (int i = 0; i < 4; i++) begin
            excluded[i] = (i >= BLOCK_NUM)
                        || (rd_valid_n && rd_block_n == 2'(i))
                        || (latest_valid_n && latest_blk_n == 2'(i))
                        || shot_excl[i];
        end

        // Scan downward so the lowest free index wins.
        for (int i = 3; i >= 0; i--) begin
            if (!excluded[i]) begin
                free_found = 1'b1;
                free_blk   = 2'(i);
            end
        end

        if (wr_frame_start) begin
            if (free_found) begin
                wr_block_n = free_blk;
                wr_ok_n    = 1'b1;
            end else begin
                wr_ok_n    = 1'b0;
                drop_cnt_n = sat_inc(drop_cnt);
            end
        end
    end

    // Writer, reader and publication state registers.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            wr_block     <= '0;
            wr_ok        <= 1'b0;
            rd_block     <= '0;
            rd_valid     <= 1'b0;
            latest_blk   <= '0;
            latest_valid <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            wr_block     <= wr_block_n;
            wr_ok        <= wr_ok_n;
            rd_block     <= rd_block_n;
            rd_valid     <= rd_valid_n;
            latest_blk   <= latest_blk_n;
            latest_valid <= latest_valid_n;
            drop_cnt     <= drop_cnt_n;
        end
    end

endmodule

// File: tb/tb_frame_block_scheduler.sv
// Directed bench for frame_block_scheduler: a BLOCK_NUM=3 instance for the
// allocation scenarios and a BLOCK_NUM=2 instance for drop-counter saturation.
module tb_frame_block_scheduler;

    logic       clk = 1'b0;
    logic       rest_n;
    logic       wr_frame_start, wr_frame_done, rd_frame_start, shot_req;
    logic [1:0] wr_block, rd_block, shot_block;
    logic       wr_ok, rd_valid, shot_valid;
    logic [7:0] drop_cnt;

    logic       b_wr_start, b_wr_done, b_rd_start, b_shot_req;
    logic [1:0] b_wr_block, b_rd_block, b_shot_block;
    logic       b_wr_ok, b_rd_valid, b_shot_valid;
    logic [7:0] b_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_block_scheduler #(.BLOCK_NUM(3)) u_dut (
        .clk(clk), .rest_n(rest_n),
        .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
        .wr_block(wr_block), .wr_ok(wr_ok),
        .rd_frame_start(rd_frame_start), .rd_block(rd_block), .rd_valid(rd_valid),
        .shot_req(shot_req), .shot_block(shot_block), .shot_valid(shot_valid),
        .drop_cnt(drop_cnt)
    );

    frame_block_scheduler #(.BLOCK_NUM(2)) u_dut2 (
        .clk(clk), .rest_n(rest_n),
        .wr_frame_start(b_wr_start), .wr_frame_done(b_wr_done),
        .wr_block(b_wr_block), .wr_ok(b_wr_ok),
        .rd_frame_start(b_rd_start), .rd_block(b_rd_block), .rd_valid(b_rd_valid),
        .shot_req(b_shot_req), .shot_block(b_shot_block), .shot_valid(b_shot_valid),
        .drop_cnt(b_drop_cnt)
    );

    // One-cycle pulse on the main instance; called and returns at a negedge.
    task automatic step(input logic ws, input logic wd, input logic rs);
        wr_frame_start = ws;
        wr_frame_done  = wd;
        rd_frame_start = rs;
        @(negedge clk);
        wr_frame_start = 1'b0;
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic step_b(input logic ws, input logic wd, input logic rs);
        b_wr_start = ws;
        b_wr_done  = wd;
        b_rd_start = rs;
        @(negedge clk);
        b_wr_start = 1'b0;
        b_wr_done  = 1'b0;
        b_rd_start = 1'b0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rest_n = 1'b0;
        @(negedge clk);
        rest_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [16:0] got;
        got = {wr_block, wr_ok, rd_block, rd_valid, shot_block, shot_valid, drop_cnt};
        n_cmp++;
        if (got !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", got);
        end
        n_cmp++;
        if ({b_wr_block, b_wr_ok, b_rd_block, b_rd_valid, b_drop_cnt} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs_b got %h want 0",
                     {b_wr_block, b_wr_ok, b_rd_block, b_rd_valid, b_drop_cnt});
        end
        // Nothing published yet: a done with wr_ok=0 is ignored, reader stays invalid.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_block !== 2'd0 || wr_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_before_publish got rd_valid=%b rd_block=%0d wr_ok=%b want 0 0 0",
                     rd_valid, rd_block, wr_ok);
        end
    endtask

    task automatic test_basic;
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (wr_block !== 2'd0 || wr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL first_alloc got blk=%0d ok=%b want 0 1", wr_block, wr_ok);
        end
        step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (wr_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL done_clears_ok got %b want 0", wr_ok);
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (rd_block !== 2'd0 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL first_read got blk=%0d valid=%b want 0 1", rd_block, rd_valid);
        end
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (wr_block !== 2'd1 || wr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL second_alloc got blk=%0d ok=%b want 1 1", wr_block, wr_ok);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (wr_block !== 2'd2 || wr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL third_alloc got blk=%0d ok=%b want 2 1", wr_block, wr_ok);
        end
    endtask

    // State in: writing 2, rd=0, latest=1.
    task automatic test_done_rd_same;
        step(1'b0, 1'b1, 1'b0);   // latest=2
        step(1'b0, 1'b0, 1'b1);   // rd=2
        step(1'b1, 1'b0, 1'b0);   // writer gets 0
        step(1'b0, 1'b1, 1'b0);   // latest=0
        step(1'b1, 1'b0, 1'b0);   // excl {2,0} -> 1
        n_cmp++;
        if (wr_block !== 2'd1) begin
            n_bad++;
            $display("FAIL setup_blk1 got %0d want 1", wr_block);
        end
        step(1'b0, 1'b1, 1'b1);   // done+rd: reader gets block 1
        n_cmp++;
        if (rd_block !== 2'd1 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL done_rd_same got blk=%0d valid=%b want 1 1", rd_block, rd_valid);
        end
        step(1'b1, 1'b0, 1'b0);   // excl {1} -> 0
        n_cmp++;
        if (wr_block !== 2'd0 || wr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL alloc_after_done_rd got blk=%0d ok=%b want 0 1", wr_block, wr_ok);
        end
    endtask

    // State in: writing 0, rd=1, latest=1.
    task automatic test_abort;
        step(1'b0, 1'b1, 1'b0);   // latest=0
        step(1'b0, 1'b0, 1'b1);   // rd=0
        step(1'b1, 1'b0, 1'b0);   // excl {0} -> 1
        step(1'b1, 1'b0, 1'b0);   // abort, reallocate -> 1
        n_cmp++;
        if (wr_block !== 2'd1 || wr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_realloc got blk=%0d ok=%b want 1 1", wr_block, wr_ok);
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (rd_block !== 2'd0) begin
            n_bad++;
            $display("FAIL abort_not_published got %0d want 0", rd_block);
        end
    endtask

    // State in: writing 1, rd=0, latest=0.
    task automatic test_back_to_back;
        step(1'b1, 1'b1, 1'b0);   // latest=1 first, then excl {0,1} -> 2
        n_cmp++;
        if (wr_block !== 2'd2 || wr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL done_wr_same got blk=%0d ok=%b want 2 1", wr_block, wr_ok);
        end
        step(1'b1, 1'b0, 1'b1);   // rd=1 first, then excl {1} -> 0
        n_cmp++;
        if (wr_block !== 2'd0 || rd_block !== 2'd1) begin
            n_bad++;
            $display("FAIL rd_wr_same got wr=%0d rd=%0d want 0 1", wr_block, rd_block);
        end
    endtask

    task automatic test_screenshot;
        apply_reset();
        step(1'b1, 1'b0, 1'b0);   // wr 0
        step(1'b0, 1'b1, 1'b0);   // latest 0
        step(1'b0, 1'b0, 1'b1);   // rd 0
        step(1'b1, 1'b0, 1'b0);   // wr 1
        step(1'b0, 1'b1, 1'b0);   // latest 1
        step(1'b1, 1'b0, 1'b0);   // wr 2
        shot_req = 1'b1;
        @(negedge clk);
`ifdef SCREENSHOT_EN
        n_cmp++;
        if (shot_block !== 2'd1 || shot_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL shot_capture got blk=%0d valid=%b want 1 1", shot_block, shot_valid);
        end
        step(1'b0, 1'b1, 1'b0);   // latest 2
        step(1'b1, 1'b0, 1'b0);   // excl {0,2,1} -> drop
        n_cmp++;
        if (wr_ok !== 1'b0 || drop_cnt !== 8'd1 || wr_block !== 2'd2) begin
            n_bad++;
            $display("FAIL shot_drop got ok=%b drop=%0d blk=%0d want 0 1 2",
                     wr_ok, drop_cnt, wr_block);
        end
        shot_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL shot_release got %b want 0", shot_valid);
        end
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (wr_block !== 2'd1 || wr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL after_shot_alloc got blk=%0d ok=%b want 1 1", wr_block, wr_ok);
        end
`else
        n_cmp++;
        if (shot_block !== 2'd0 || shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL shot_tied got blk=%0d valid=%b want 0 0", shot_block, shot_valid);
        end
        step(1'b0, 1'b1, 1'b0);   // latest 2
        step(1'b1, 1'b0, 1'b0);   // excl {0,2} -> 1, shot ignored
        n_cmp++;
        if (wr_block !== 2'd1 || wr_ok !== 1'b1 || drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL shot_ignored got blk=%0d ok=%b drop=%0d want 1 1 0",
                     wr_block, wr_ok, drop_cnt);
        end
        shot_req = 1'b0;
        @(negedge clk);
`endif
    endtask

    // Reset asserted between edges must clear outputs before the next edge.
    task automatic test_async_reset;
        step(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2 rest_n = 1'b0;
        #1;
        n_cmp++;
        if ({wr_block, wr_ok, rd_block, rd_valid, drop_cnt} !== 14'd0) begin
            n_bad++;
            $display("FAIL async_reset got %h want 0",
                     {wr_block, wr_ok, rd_block, rd_valid, drop_cnt});
        end
        @(negedge clk);
        rest_n = 1'b1;
        @(negedge clk);
    endtask

    // BLOCK_NUM=2 with reader on 0 and latest on 1 leaves nothing free.
    task automatic test_drop_saturate;
        step_b(1'b1, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 1'b0);
        step_b(1'b0, 1'b0, 1'b1);
        step_b(1'b1, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 1'b0);
        b_wr_start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_drop_cnt !== 8'd1 || b_wr_ok !== 1'b0 || b_wr_block !== 2'd1) begin
            n_bad++;
            $display("FAIL first_drop got drop=%0d ok=%b blk=%0d want 1 0 1",
                     b_drop_cnt, b_wr_ok, b_wr_block);
        end
        repeat (253) @(negedge clk);
        n_cmp++;
        if (b_drop_cnt !== 8'd254) begin
            n_bad++;
            $display("FAIL drop_254 got %0d want 254", b_drop_cnt);
        end
        repeat (46) @(negedge clk);
        b_wr_start = 1'b0;
        n_cmp++;
        if (b_drop_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL drop_saturate got %0d want 255", b_drop_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (b_drop_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL drop_hold got %0d want 255", b_drop_cnt);
        end
    endtask

    initial begin
        rest_n = 1'b0;
        wr_frame_start = 1'b0; wr_frame_done = 1'b0; rd_frame_start = 1'b0; shot_req = 1'b0;
        b_wr_start = 1'b0; b_wr_done = 1'b0; b_rd_start = 1'b0; b_shot_req = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rest_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_done_rd_same();
        test_abort();
        test_back_to_back();
        test_screenshot();
        test_async_reset();
        test_drop_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_block_scheduler.md
# frame_block_scheduler

Allocates the SDRAM frame-buffer blocks shared between the camera write path (frame_write) and the display read path (frame_read). It hands the writer a free block at every frame start, publishes the newest completed block to the reader, and optionally freezes one block for a screenshot. All of this happens without tearing. It drives the writer and reader block selects (occupy_block_num / occupy_block_num_write) and sits beside the avl_bus_n2n / sdram_controller path in the top level.

## Interface
- BLOCK_NUM, 3, number of frame blocks in SDRAM; legal values 2..4; block indices are 2 bits wide.
- clk  in  1  system clock, the same clock as frame_write, frame_read and the Avalon bus.
- rest_n  in  1  reset, asynchronous, active-low.
- wr_frame_start  in  1  one-cycle pulse: the writer begins a new frame.
- wr_frame_done  in  1  one-cycle pulse: the writer has finished the current frame.
- wr_block  out  2  block the writer must fill.
- wr_ok  out  1  high when wr_block is a valid allocation; when low, the writer discards the frame.
- rd_frame_start  in  1  one-cycle pulse: the reader begins a new frame.
- rd_block  out  2  block the reader must scan.
- rd_valid  out  1  high once any frame has been published to the reader.
- shot_req  in  1  level: hold a screenshot while high (SCREENSHOT_EN only).
- shot_block  out  2  frozen block; shot_valid  out  1  screenshot held.
- drop_cnt  out  8  count of frames dropped because no block was free; saturates at 255.

## Operation
- Internal state: wr_blk, rd_blk, latest_blk, latest_valid, shot_blk, shot_valid, wr_ok, drop_cnt, and shot_req_d (edge-detect register).
- A block is excluded from allocation if any of these hold:
  - it equals rd_blk and rd_valid is high;
  - it equals latest_blk and latest_valid is high;
  - it equals shot_blk and shot_valid is high.
- On wr_frame_start:
  - Pick the lowest-index non-excluded block below BLOCK_NUM, then set wr_block to it and wr_ok to 1.
  - If no block is free, set wr_ok to 0, leave wr_block unchanged and increment drop_cnt (saturating).
- On wr_frame_done with wr_ok=1: set latest_blk to wr_blk and latest_valid to 1, then clear wr_ok.
- wr_frame_done with wr_ok=0 is ignored.
- wr_frame_start without a preceding done aborts the current frame: the aborted block is never published, and allocation reruns.
- On rd_frame_start with latest_valid=1: set rd_blk to latest_blk and rd_valid to 1. With latest_valid=0, the reader keeps its block and rd_valid stays 0.
- Evaluation order for simultaneous events in one cycle: wr_frame_done, then rd_frame_start, then wr_frame_start.
  - done+rd_start: the reader receives the block just completed.
  - rd_start+wr_start: the writer's allocation excludes the reader's new block.
  - done+wr_start: the writer excludes the newly published block.
- Screenshot:
  - On a rising edge of shot_req with latest_valid=1: set shot_blk to latest_blk and shot_valid to 1. A rising edge while latest_valid=0 does nothing.
  - On a falling edge of shot_req: clear shot_valid.
- Guarantees: BLOCK_NUM=3 never drops without a screenshot; BLOCK_NUM=4 never drops with one.

## Timing
- Reset values of all outputs are 0: wr_block, wr_ok, rd_block, rd_valid, shot_block, shot_valid, drop_cnt.
- Internal reset values: latest_valid=0 and shot_req_d=0.
- Assertion of rest_n is asynchronous, including mid-frame. There is no drain; the writer and reader must restart on the next start pulse.
- wr_block, wr_ok and drop_cnt are valid the cycle after wr_frame_start.
- rd_block and rd_valid are valid the cycle after rd_frame_start.
- shot_block and shot_valid are valid the cycle after the shot_req edge.
- All outputs are registered; there are no combinational input-to-output paths.
- Start and done pulses are assumed single-cycle. A level held high is treated as a new event every cycle.

## Configuration
- SCREENSHOT_EN defined: shot_req is sampled and screenshot exclusion is active.
- SCREENSHOT_EN undefined:
  - shot_req is ignored;
  - shot_valid and shot_block are tied to 0;
  - the exclusion logic and shot registers are removed.

## Test plan
- Reset, then idle: all outputs read 0. Assert rest_n low mid-frame: outputs return to 0 asynchronously within the same cycle.
- BLOCK_NUM=3, wr_start → wr_block=0, wr_ok=1; wr_done; rd_start → rd_block=0, rd_valid=1; wr_start → wr_block=1; wr_done; wr_start → wr_block=2.
- wr_done and rd_start in the same cycle while writing block 1 → rd_block=1 next cycle; the following wr_start allocates from blocks not in {1}.
- wr_start twice with no done while writing block 1 (latest=0) → latest unchanged; a subsequent rd_start yields rd_block=0.
- SCREENSHOT_EN, BLOCK_NUM=3 with rd=0, latest=1, shot_req rising → shot_block=1; wr_done publishes block 2; wr_start → wr_ok=0, drop_cnt=1. Drop shot_req; wr_start → wr_block=1, wr_ok=1.
- Force 300 drops → drop_cnt=255 and holds there.
